// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : MEM-stage data memory controller. It owns a byte-writable RAM
//            and serves MIPS loads and stores. Its load FSM covers the RAM
//            read latency, and it flags address errors and range errors.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DEPTH_LOG2   = 14,
    parameter int READ_LATENCY = 1,
    parameter int CHECK_RANGE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  memSize,
    input  logic        memSign,
    input  logic        flush,
    output logic [31:0] dout,
    output logic        requireStall,
    output logic        exception,
    output logic        excStore,
    output logic        outOfRange,
    output logic [31:0] badVAddr
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [2:0] C_LATENCY = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;

    logic                  w_idle;
    logic                  w_req;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_fault;
    logic                  w_store;
    logic                  w_load;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_shifted;
    logic [DEPTH_LOG2-1:0] w_widx;

    logic [3:0][7:0] mem [DEPTH];
    logic [31:0]     rd_pipe_q [READ_LATENCY];

    // Requests are only accepted in IDLE; WAIT and DONE ignore the inputs.
    assign w_idle     = (state_q == S_IDLE) && !rst;
    assign w_req      = memWrite || memRead;
    assign w_misalign = (memSize == 2'b11)
                     || ((memSize == SIZE_HALF) && addr[0])
                     || ((memSize == SIZE_WORD) && (addr[1:0] != 2'b00));
    assign w_oor      = (CHECK_RANGE != 0) && ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_fault    = w_idle && w_req && (w_misalign || w_oor);
    assign w_store    = w_idle && memWrite && !w_fault && !flush;
    assign w_load     = w_idle && !memWrite && memRead && !w_fault && !flush;
    assign w_widx     = addr[DEPTH_LOG2+1:2];

    assign exception    = w_fault;
    assign excStore     = w_fault && memWrite;
    assign outOfRange   = w_fault && !w_misalign;
    assign badVAddr     = w_fault ? addr : 32'd0;
    assign requireStall = w_load || ((state_q == S_WAIT) && !rst);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = din;
        case (memSize)
            SIZE_BYTE: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{din[7:0]}};
            end
            SIZE_HALF: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{din[15:0]}};
            end
            SIZE_WORD: begin
                w_be    = 4'b1111;
                w_wdata = din;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = din;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_store && w_be[i]) begin
                mem[w_widx][i] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Read pipeline: stage 0 is the RAM output register; the rest add latency.
    always_ff @(posedge clk) begin
        if (w_load) begin
            rd_pipe_q[0] <= mem[w_widx];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sign_d  = sign_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_load) begin
                    state_d = S_WAIT;
                    cnt_d   = C_LATENCY;
                    lane_d  = addr[1:0];
                    size_d  = memSize;
                    sign_d  = memSign;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_DONE;
                        data_d  = rd_pipe_q[READ_LATENCY-1];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
        end
    end

    // Word loads are always lane 0, so the shifted word is the raw word for them.
    assign w_shifted = data_q >> {lane_q, 3'b000};

    always_comb begin
        dout = 32'd0;
        if ((state_q == S_DONE) && !rst) begin
            case (size_q)
                SIZE_BYTE: dout = sign_q ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                         : {24'd0, w_shifted[7:0]};
                SIZE_HALF: dout = sign_q ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                         : {16'd0, w_shifted[15:0]};
                default:   dout = w_shifted;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Self-checking bench for data_memory_ctrl. It uses a byte-level
//            memory model and checks the outputs cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, din;
    logic        memWrite, memRead;
    logic [1:0]  memSize;
    logic        memSign, flush;
    logic [31:0] dout, badVAddr;
    logic        requireStall, exception, excStore, outOfRange;

    logic        b_rst;
    logic [31:0] b_addr, b_din;
    logic        b_memWrite, b_memRead;
    logic [1:0]  b_memSize;
    logic        b_memSign, b_flush;
    logic [31:0] b_dout, b_badVAddr;
    logic        b_requireStall, b_exception, b_excStore, b_outOfRange;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_LOG2(14), .READ_LATENCY(L), .CHECK_RANGE(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .memWrite(memWrite),
        .memRead(memRead), .memSize(memSize), .memSign(memSign), .flush(flush),
        .dout(dout), .requireStall(requireStall), .exception(exception),
        .excStore(excStore), .outOfRange(outOfRange), .badVAddr(badVAddr)
    );

    data_memory_ctrl #(.DEPTH_LOG2(14), .READ_LATENCY(1), .CHECK_RANGE(0)) dut_alias (
        .clk(clk), .rst(b_rst), .addr(b_addr), .din(b_din), .memWrite(b_memWrite),
        .memRead(b_memRead), .memSize(b_memSize), .memSign(b_memSign), .flush(b_flush),
        .dout(b_dout), .requireStall(b_requireStall), .exception(b_exception),
        .excStore(b_excStore), .outOfRange(b_outOfRange), .badVAddr(b_badVAddr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mm [int unsigned];
    int          age = 0;
    logic [31:0] pend;
    bit          pend_ok;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_read(input logic [31:0] a, input logic [1:0] sz,
                                      input logic sg, output logic [31:0] v);
        int n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (!mm.exists(a + 32'(i))) return 1'b0;
            v = v | (32'(mm[a + 32'(i)]) << (8 * i));
        end
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return 1'b1;
    endfunction

    always @(negedge clk) begin : model
        logic [31:0] e_dout, e_bad;
        logic        e_stall, e_exc, e_st, e_oor;
        bit          mis, oor, fault;
        int          age_n;
        e_dout = 0; e_bad = 0; e_stall = 0; e_exc = 0; e_st = 0; e_oor = 0;
        age_n = 0;
        if (rst) begin
            age_n = 0;
        end else if (age == 0) begin
            mis   = (memSize == 2'b11) || (memSize == 2'b01 && addr[0])
                 || (memSize == 2'b10 && addr[1:0] != 2'b00);
            oor   = addr >= 32'h0001_0000;
            fault = (memWrite || memRead) && (mis || oor);
            e_exc = fault;
            e_st  = fault && memWrite;
            e_oor = fault && !mis;
            e_bad = fault ? addr : 32'd0;
            if (!fault && !flush && memWrite) begin
                for (int i = 0; i < nbytes(memSize); i++)
                    mm[addr + 32'(i)] = din[8*i +: 8];
            end else if (!fault && !flush && memRead) begin
                e_stall = 1;
                age_n   = 1;
                pend_ok = model_read(addr, memSize, memSign, pend);
            end
        end else if (age <= L) begin
            e_stall = 1;
            age_n   = flush ? 0 : age + 1;
        end else begin
            e_dout = pend;
            age_n  = 0;
        end
        chk("m_stall", 32'(requireStall), 32'(e_stall));
        chk("m_exception", 32'(exception), 32'(e_exc));
        chk("m_excStore", 32'(excStore), 32'(e_st));
        chk("m_outOfRange", 32'(outOfRange), 32'(e_oor));
        chk("m_badVAddr", badVAddr, e_bad);
        if (age <= L || pend_ok) chk("m_dout", dout, e_dout);
        age = age_n;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg, input logic fl);
        memWrite = w; memRead = r; addr = a; din = d; memSize = sz; memSign = sg; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 32'd0, 32'd0, 2'b00, 0, 0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        drive(1, 0, a, d, sz, 0, 0);
        @(negedge clk);
        chk("store_nostall", 32'(requireStall), 32'd0);
        step();
        idle();
    endtask

    task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input bit noise, input logic [31:0] expv);
        int stalls = 0;
        bit done   = 0;
        drive(0, 1, a, 32'd0, sz, sg, 0);
        @(negedge clk);
        if (requireStall) stalls++;
        step();
        if (noise) drive(1, 0, 32'h104, 32'hFFFF_FFFF, 2'b10, 1, 0);
        else idle();
        for (int n = 0; n < 12 && !done; n++) begin
            @(negedge clk);
            if (requireStall) stalls++;
            else begin
                done = 1;
                chk(nm, dout, expv);
                chk("stall_cycles", 32'(stalls), 32'(L + 1));
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL %s: load never completed, stall still high", nm);
        end
        step();
        idle();
    endtask

    task automatic do_fault(input string nm, input logic w, input logic r, input logic [31:0] a,
                            input logic [1:0] sz, input logic e_st, input logic e_oor);
        drive(w, r, a, 32'hFFFF_FFFF, sz, 0, 0);
        @(negedge clk);
        chk({nm, "_exc"}, 32'(exception), 32'd1);
        chk({nm, "_excStore"}, 32'(excStore), 32'(e_st));
        chk({nm, "_oor"}, 32'(outOfRange), 32'(e_oor));
        chk({nm, "_bad"}, badVAddr, a);
        chk({nm, "_stall"}, 32'(requireStall), 32'd0);
        step();
        idle();
    endtask

    initial begin
        rst = 1;
        drive(0, 1, 32'h0001_0000, 32'd0, 2'b10, 0, 0);
        b_rst = 1; b_addr = 0; b_din = 0; b_memWrite = 0; b_memRead = 0;
        b_memSize = 0; b_memSign = 0; b_flush = 0;
        @(negedge clk);
        chk("rst_exception", 32'(exception), 32'd0);
        chk("rst_stall", 32'(requireStall), 32'd0);
        chk("rst_dout", dout, 32'd0);
        step();
        step();
        idle();
        rst = 0;
        b_rst = 0;

        // Range check disabled: 0x10000 aliases word 0 without fault
        b_memWrite = 1; b_addr = 32'h0; b_din = 32'h5A5A_A5A5; b_memSize = 2'b10;
        @(negedge clk);
        chk("alias_st_exc", 32'(b_exception), 32'd0);
        step();
        b_memWrite = 0; b_memRead = 1; b_addr = 32'h0001_0000;
        @(negedge clk);
        chk("alias_ld_exc", 32'(b_exception), 32'd0);
        chk("alias_issue_stall", 32'(b_requireStall), 32'd1);
        step();
        b_memRead = 0;
        @(negedge clk);
        chk("alias_wait_stall", 32'(b_requireStall), 32'd1);
        step();
        @(negedge clk);
        chk("alias_done_stall", 32'(b_requireStall), 32'd0);
        chk("alias_dout", b_dout, 32'h5A5A_A5A5);
        step();

        do_store(32'h100, 32'hDEAD_BEEF, 2'b10);
        do_load("lw_100", 32'h100, 2'b10, 0, 0, 32'hDEAD_BEEF);

        do_store(32'h103, 32'h0000_0080, 2'b00);
        do_load("lb_103", 32'h103, 2'b00, 1, 0, 32'hFFFF_FF80);
        do_load("lbu_103", 32'h103, 2'b00, 0, 0, 32'h0000_0080);
        do_load("lbu_100", 32'h100, 2'b00, 0, 0, 32'h0000_00EF);
        do_load("lbu_101", 32'h101, 2'b00, 0, 0, 32'h0000_00BE);
        do_load("lbu_102", 32'h102, 2'b00, 0, 0, 32'h0000_00AD);

        do_store(32'h102, 32'h0000_1234, 2'b01);
        do_load("lh_102", 32'h102, 2'b01, 1, 0, 32'h0000_1234);
        do_load("lh_100", 32'h100, 2'b01, 1, 0, 32'hFFFF_BEEF);
        do_fault("lh_101", 0, 1, 32'h101, 2'b01, 0, 0);

        do_store(32'h4, 32'h0102_0304, 2'b10);
        do_fault("sw_6", 1, 0, 32'h6, 2'b10, 1, 0);
        do_load("lw_4", 32'h4, 2'b10, 0, 0, 32'h0102_0304);
        do_fault("lw_oor", 0, 1, 32'h0001_0000, 2'b10, 0, 1);
        do_fault("sw_oor", 1, 0, 32'h0001_0000, 2'b10, 1, 1);
        do_fault("size11", 0, 1, 32'h8, 2'b11, 0, 0);

        // Flush in the first WAIT cycle cancels the load
        drive(0, 1, 32'h100, 32'd0, 2'b10, 0, 0);
        @(negedge clk);
        step();
        drive(0, 0, 32'd0, 32'd0, 2'b00, 0, 1);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        chk("flush_stall", 32'(requireStall), 32'd0);
        chk("flush_dout", dout, 32'd0);
        step();
        do_load("lw_after_flush", 32'h100, 2'b10, 0, 0, 32'h1234_BEEF);

        // A store request during WAIT must not reach the RAM
        do_store(32'h104, 32'h1122_3344, 2'b10);
        do_load("lw_noise", 32'h100, 2'b10, 0, 1, 32'h1234_BEEF);
        do_load("lw_104", 32'h104, 2'b10, 0, 0, 32'h1122_3344);

        // Reset while WAIT aborts the load
        drive(0, 1, 32'h100, 32'd0, 2'b10, 0, 0);
        @(negedge clk);
        step();
        idle();
        rst = 1;
        @(negedge clk);
        chk("rstwait_stall", 32'(requireStall), 32'd0);
        chk("rstwait_dout", dout, 32'd0);
        step();
        rst = 0;
        @(negedge clk);
        chk("postrst_stall", 32'(requireStall), 32'd0);
        chk("postrst_dout", dout, 32'd0);
        step();

        // Both requests high: store wins, no stall
        drive(1, 1, 32'h200, 32'hCAFE_F00D, 2'b10, 0, 0);
        @(negedge clk);
        chk("both_stall", 32'(requireStall), 32'd0);
        chk("both_exc", 32'(exception), 32'd0);
        step();
        idle();
        do_load("lw_200", 32'h200, 2'b10, 0, 0, 32'hCAFE_F00D);

        // Flush in IDLE suppresses store and load
        drive(1, 0, 32'h200, 32'h0, 2'b10, 0, 1);
        @(negedge clk);
        step();
        drive(0, 1, 32'h200, 32'h0, 2'b10, 0, 1);
        @(negedge clk);
        chk("idleflush_ld_stall", 32'(requireStall), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("idleflush_dout", dout, 32'd0);
        step();
        do_load("lw_200_kept", 32'h200, 2'b10, 0, 0, 32'hCAFE_F00D);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised data-memory controller for the MEM stage of the 5-stage MIPS pipeline. It owns an inferred byte-writable synchronous RAM and serves LB/LBU/LH/LHU/LW/SB/SH/SW. It supports a configurable RAM read latency through a stall FSM, and raises address-error exceptions, split into load and store kinds, plus an optional out-of-range bus error. It adds a pipeline flush that cancels an in-flight load.

Parameters:
DEPTH_LOG2, 14, log2 of RAM depth in 32-bit words (word index = addr[DEPTH_LOG2+1:2])
READ_LATENCY, 1, RAM read pipeline stages, legal range 1..4
CHECK_RANGE, 1, 1 = flag addresses beyond RAM as out-of-range; 0 = ignore upper address bits

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
addr  input  32  byte address from ALU
din  input  32  store data (low bits used for SB/SH)
memWrite  input  1  store request
memRead  input  1  load request
memSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved
memSign  input  1  1 = sign-extend sub-word loads
flush  input  1  cancel in-flight load (pipeline exception/redirect)
dout  output  32  load result, valid only in the DONE cycle
requireStall  output  1  hold the pipeline
exception  output  1  address error or out-of-range error this cycle
excStore  output  1  1 = exception caused by a store (AdES), 0 = by a load (AdEL)
outOfRange  output  1  exception is a range error, not a misalignment
badVAddr  output  32  faulting address when exception=1, else 0

Behaviour:
- Request decode:
  - memWrite has priority. If memWrite and memRead are both high, the access is a store and memRead is ignored.
  - memSize=11 with any request is treated as a misaligned access, so exception=1.
- Misalignment:
  - Halfword access with addr[0]!=0 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
- Range check: when CHECK_RANGE=1, an access is out of range if addr[31:DEPTH_LOG2+2] != 0. outOfRange=1 only if the address is aligned.
- exception, excStore, outOfRange and badVAddr:
  - Combinational, evaluated in IDLE only; forced 0 in all other states.
  - A faulting access causes no RAM enable, no write and no stall.
- Stores:
  - Single cycle, never stall.
  - Byte-enables are decoded from memSize/addr[1:0]: byte → one-hot lane; halfword → 0011 or 1100; word → 1111.
  - din is replicated into the addressed lane(s).
  - RAM is written at the clk edge.
- Loads, FSM states IDLE, WAIT, DONE:
  - IDLE → WAIT on a valid load. The RAM read is issued and addr[1:0], memSize and memSign are latched. A wait counter is loaded with READ_LATENCY.
  - WAIT: the counter decrements each cycle. When it reaches 1, the state goes to DONE and RAM data is captured into a data register.
  - DONE: dout is driven from the data register, with lane select and extension using the latched fields. The state returns to IDLE unconditionally.
  - requireStall=1 in the issue cycle and in every WAIT cycle, and 0 in DONE.
  - A load therefore occupies READ_LATENCY+1 cycles with READ_LATENCY+1 stall cycles; dout is valid in cycle READ_LATENCY+1 after issue.
  - Back-to-back loads each pay full latency. A store in the cycle after DONE is accepted normally.
  - Changes to addr, memSize or memSign during WAIT are ignored because the latched values are used. memWrite during WAIT is ignored and does not write RAM.
- Extension:
  - Byte result = memSign ? sign-extend(byte) : zero-extend(byte).
  - Halfword result is extended the same way.
  - Word result passes through unchanged.
- dout is 0 outside DONE (no X).
- flush:
  - In WAIT or DONE: state goes to IDLE next cycle, requireStall=0 from the next cycle, and the data register is not updated.
  - In IDLE: suppresses the RAM write/enable of the current request and drives requireStall=0.
- Reset: state IDLE, counter 0, data register 0. While rst=1 all outputs are 0 and no RAM write occurs. rst during a load aborts it. RAM contents are not reset.

Test Plan:
- SW addr=0x100 din=0xDEADBEEF, then LW 0x100 with READ_LATENCY=2 → requireStall=1 for 3 cycles, then dout=0xDEADBEEF for 1 cycle with stall=0.
- SB 0x103 din=0x80, then LB 0x103 → dout=0xFFFFFF80; LBU 0x103 → dout=0x00000080; bytes 0x100..0x102 unchanged.
- SH 0x102 din=0x1234; LH 0x102 → 0x00001234; LH 0x101 → exception=1, excStore=0, badVAddr=0x101, no stall.
- SW 0x6 → exception=1, excStore=1, outOfRange=0, RAM unchanged. With DEPTH_LOG2=14, LW 0x00010000 → exception=1, outOfRange=1. The same access with CHECK_RANGE=0 → no exception, aliased read.
- LW issued, flush asserted in the first WAIT cycle → requireStall=0 next cycle, dout stays 0, FSM IDLE; a following LW completes normally.
- rst asserted mid-WAIT → all outputs 0 the next cycle. memWrite and memRead both high at 0x200 → store performed, no stall.
